if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP, default 32'h0000_0013: instruction word driven on bubbles.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 stall_i  in  1  hazard unit: hold ID-facing outputs.
REQ-006 redirect_i  in  1  taken branch, jump or trap; priority over stall_i.
REQ-007 redirect_pc_i  in  32  new fetch address, sampled when redirect_i=1.
REQ-008 imem_req  out  1  instruction bus request.
REQ-009 imem_addr  out  32  request address.
REQ-010 imem_ack  in  1  bus response valid.
REQ-011 imem_err  in  1  bus error, meaningful only with imem_ack=1.
REQ-012 imem_data  in  32  fetched word, meaningful only with imem_ack=1.
REQ-013 inst  out  32  instruction to ID.
REQ-014 pc_o  out  32  PC of inst.
REQ-015 pc4_o  out  32  pc_o+4, modulo 2^32.
REQ-016 valid_o  out  1  inst/exc_o carry a real slot.
REQ-017 exc_o  out  4  4'h0 none, 4'h1 fetch misaligned, 4'h2 fetch access fault.

Function
REQ-018 States: BOOT, FETCH, HOLD, DRAIN, HALT; internal regs: fetch pc, 32-bit skid buffer plus its exc, target pc.
REQ-019 imem_req=1 in FETCH and DRAIN, 0 otherwise.
REQ-020 imem_addr=fetch pc, held stable until imem_ack.
REQ-021 BOOT: no request; next edge goes to FETCH.
REQ-022 Output regs (inst, pc_o, pc4_o, valid_o, exc_o) load only on edges with stall_i=0 or redirect_i=1.
REQ-023 Bubble load: inst=NOP, valid_o=0, exc_o=0, pc_o/pc4_o unchanged.
REQ-024 FETCH, ack, err=0, stall_i=0: outputs take imem_data, fetch pc, fetch pc+4, valid_o=1, exc_o=0; fetch pc += 4; stay in FETCH, so back-to-back acks sustain one instruction per cycle.
REQ-025 FETCH, ack, stall_i=1: word goes to skid buffer; fetch pc += 4; go to HOLD.
REQ-026 FETCH, no ack, stall_i=0: bubble load.
REQ-027 HOLD, stall_i=0: outputs load from skid buffer; go to FETCH.
REQ-028 HOLD, stall_i=1: hold, no request.
REQ-029 FETCH, ack, err=1: the slot carries exc_o=4'h2, inst=NOP, valid_o=1, pc_o=faulting pc; go to HALT. Through the skid buffer if stalled.
REQ-030 HALT: no requests; bubble loads; leave only on redirect.
REQ-031 Redirect, any state: bubble load, skid buffer cleared.
REQ-032 Redirect in FETCH without ack the same cycle: target pc=redirect_pc_i; go to DRAIN.
REQ-033 Redirect in other states, or in FETCH with ack the same cycle: ack data discarded; fetch pc=redirect_pc_i; go to FETCH.
REQ-034 DRAIN: keep the old request until ack; discard data and err; then fetch pc=target pc; go to FETCH. A new redirect in DRAIN overwrites target pc.
REQ-035 Misaligned target (redirect_pc_i[1:0]!=0): no bus request; next unstalled load gives exc_o=4'h1, valid_o=1, inst=NOP, pc_o=target; then HALT.
REQ-036 Fetch pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no exception.

Reset
REQ-037 rst_n=0 forces immediately: state BOOT, fetch pc=RESET_ADDR, inst=NOP, pc_o=0, pc4_o=0, valid_o=0, exc_o=0, skid buffer empty, imem_req=0.
REQ-038 Reset asserted with a request outstanding: request abandoned; a late ack after reset release is ignored unless in FETCH.
REQ-039 First imem_req=1 occurs one clock after rst_n rises, with imem_addr=RESET_ADDR.

Verification
REQ-040 Reset release, single-cycle ack with data 32'h00500093 -> first request at 0x0; next cycle inst=0x00500093, pc_o=0, pc4_o=4, valid_o=1.
REQ-041 Zero-wait bus, stall_i=1 for 3 cycles mid-stream -> outputs frozen; one word in skid buffer; no requests in HOLD; resumes with no duplicated or lost pc.
REQ-042 Redirect to 0x100 with request outstanding, ack 2 cycles later -> old data dropped; next imem_addr=0x100; valid_o=0 until the 0x100 word arrives.
REQ-043 Redirect to 0x102 -> no request; exc_o=1, pc_o=0x102, valid_o=1; then HALT until redirect to 0x200 resumes fetch.
REQ-044 ack with err=1 at 0x40 -> exc_o=2, pc_o=0x40, valid_o=1; imem_req stays 0 afterward.
REQ-045 Redirect and ack on the same edge while stall_i=1 -> data discarded, bubble loaded, fetch resumes at the target.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
// A request is held with a stable address until the slave answers with ack;
// err and data are only meaningful in the ack cycle.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_err,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_err,
        output imem_data
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage. Issues one request per cycle on a zero-wait bus,
// parks one word in a skid buffer when ID stalls, drains an in-flight request
// after a redirect, and stops fetching (HALT) after any fetch exception until
// the next redirect.
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    if_stage_if.master        imem,
    output logic [31:0]       inst,
    output logic [31:0]       pc_o,
    output logic [31:0]       pc4_o,
    output logic              valid_o,
    output logic [3:0]        exc_o
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_t;

    localparam logic [3:0] EXC_NONE     = 4'h0;
    localparam logic [3:0] EXC_MISALIGN = 4'h1;
    localparam logic [3:0] EXC_ACCESS   = 4'h2;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] target_pc, target_pc_n;
    logic [31:0] skid_data, skid_data_n;
    logic [3:0]  skid_exc, skid_exc_n;

    logic        misaligned;
    logic        req;
    logic        ack;

    // Next values for the ID-facing registers; the defaults describe a bubble.
    logic        out_load;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_valid;
    logic [3:0]  out_exc;

    // A misaligned fetch pc never reaches the bus; it becomes an exception slot.
    assign misaligned     = (fetch_pc[1:0] != 2'b00);
    assign req            = ((state == S_FETCH) && !misaligned) || (state == S_DRAIN);
    // Acks are only meaningful against our own outstanding request.
    assign ack            = imem.imem_ack && req;
    assign imem.imem_req  = req;
    assign imem.imem_addr = fetch_pc;

    // Next-state, fetch-pc, skid-buffer and output-slot selection.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would infer a latch.
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        target_pc_n = target_pc;
        skid_data_n = skid_data;
        skid_exc_n  = skid_exc;
        out_load    = !stall_i || redirect_i;
        out_inst    = NOP;
        out_pc      = pc_o;
        out_valid   = 1'b0;
        out_exc     = EXC_NONE;

        if (redirect_i) begin
            // Redirect wins over stall: bubble, flush the skid buffer.
            skid_data_n = NOP;
            skid_exc_n  = EXC_NONE;
            if (req && !ack) begin
                // Old request still in flight: remember the target and drain.
                target_pc_n = redirect_pc_i;
                state_n     = S_DRAIN;
            end else begin
                fetch_pc_n = redirect_pc_i;
                state_n    = S_FETCH;
            end
        end else begin
            case (state)
                S_BOOT: begin
                    state_n = S_FETCH;
                end
                S_FETCH: begin
                    if (misaligned) begin
                        if (!stall_i) begin
                            out_pc    = fetch_pc;
                            out_valid = 1'b1;
                            out_exc   = EXC_MISALIGN;
                            state_n   = S_HALT;
                        end
                    end else if (ack) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        if (stall_i) begin
                            skid_data_n = imem.imem_err ? NOP : imem.imem_data;
                            skid_exc_n  = imem.imem_err ? EXC_ACCESS : EXC_NONE;
                            state_n     = S_HOLD;
                        end else begin
                            out_inst  = imem.imem_err ? NOP : imem.imem_data;
                            out_pc    = fetch_pc;
                            out_valid = 1'b1;
                            out_exc   = imem.imem_err ? EXC_ACCESS : EXC_NONE;
                            state_n   = imem.imem_err ? S_HALT : S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    // fetch_pc already advanced past the parked word.
                    if (!stall_i) begin
                        out_inst  = skid_data;
                        out_pc    = fetch_pc - 32'd4;
                        out_valid = 1'b1;
                        out_exc   = skid_exc;
                        state_n   = (skid_exc != EXC_NONE) ? S_HALT : S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ack) begin
                        fetch_pc_n = target_pc;
                        state_n    = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_n = S_HALT;
                end
                default: begin
                    state_n = S_BOOT;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_BOOT;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_n;
        end
    end

    // Fetch pc, redirect target and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the skid buffer is a single word, so it is reset to an
            // empty NOP entry like any other register.
            fetch_pc  <= RESET_ADDR;
            target_pc <= RESET_ADDR;
            skid_data <= NOP;
            skid_exc  <= EXC_NONE;
        end else begin
            fetch_pc  <= fetch_pc_n;
            target_pc <= target_pc_n;
            skid_data <= skid_data_n;
            skid_exc  <= skid_exc_n;
        end
    end

    // ID-facing output registers; a bubble leaves pc_o/pc4_o untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst    <= NOP;
            pc_o    <= 32'h0;
            pc4_o   <= 32'h0;
            valid_o <= 1'b0;
            exc_o   <= EXC_NONE;
        end else if (out_load) begin
            inst    <= out_inst;
            valid_o <= out_valid;
            exc_o   <= out_exc;
            if (out_valid) begin
                pc_o  <= out_pc;
                pc4_o <= out_pc + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. A bus model answers requests after a
// programmable latency; the stimulus pushes each expected slot into a
// scoreboard queue and a monitor pops and compares on every loaded valid slot.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  exc;
    } slot_t;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;
    logic        valid_o;
    logic [3:0]  exc_o;

    if_stage_if bus ();

    if_stage #(
        .RESET_ADDR (32'h0000_0000),
        .NOP        (NOP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (bus),
        .inst          (inst),
        .pc_o          (pc_o),
        .pc4_o         (pc4_o),
        .valid_o       (valid_o),
        .exc_o         (exc_o)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    slot_t       sb[$];
    int          lat      = 0;
    logic [31:0] err_addr = 32'h0000_0040;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'h0050_0093 ^ {a[11:0], 20'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_ok(input logic [31:0] pc);
        slot_t s;
        s.pc = pc; s.inst = data_of(pc); s.exc = 4'h0;
        sb.push_back(s);
    endtask

    task automatic push_exc(input logic [31:0] pc, input logic [3:0] exc);
        slot_t s;
        s.pc = pc; s.inst = NOP; s.exc = exc;
        sb.push_back(s);
    endtask

    task automatic neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bus model: acks after `lat` waiting cycles; err on err_addr.
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_ack  = 1'b0;
        bus.imem_err  = 1'b0;
        bus.imem_data = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.imem_req) begin
                if (cnt >= lat) begin
                    bus.imem_ack  = 1'b1;
                    bus.imem_data = data_of(bus.imem_addr);
                    bus.imem_err  = (bus.imem_addr == err_addr);
                    cnt = 0;
                end else begin
                    bus.imem_ack = 1'b0;
                    bus.imem_err = 1'b0;
                    cnt++;
                end
            end else begin
                bus.imem_ack = 1'b0;
                bus.imem_err = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: a valid slot loaded on the last edge is popped and compared.
    initial begin
        logic  ld;
        slot_t e;
        forever begin
            @(posedge clk);
            ld = rst_n && (!stall_i || redirect_i);
            @(negedge clk);
            if (ld && valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected slot pc", pc_o, 32'hxxxx_xxxx);
                end else begin
                    e = sb.pop_front();
                    check("slot pc",   pc_o,  e.pc);
                    check("slot pc4",  pc4_o, e.pc + 32'd4);
                    check("slot inst", inst,  e.inst);
                    check("slot exc",  {28'h0, exc_o}, {28'h0, e.exc});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus; Nk denotes the k-th falling edge after reset release.
    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        neg(3);
        check("reset inst",  inst,  NOP);
        check("reset pc",    pc_o,  32'h0);
        check("reset pc4",   pc4_o, 32'h0);
        check("reset valid", {31'h0, valid_o}, 32'h0);
        check("reset req",   {31'h0, bus.imem_req}, 32'h0);

        // Stream with a 3-cycle stall in the middle.
        for (int a = 0; a <= 24; a += 4) push_ok(a);
        rst_n = 1'b1;                                                 // N0
        check("boot no req", {31'h0, bus.imem_req}, 32'h0);
        neg(1);                                                       // N1
        check("first req",  {31'h0, bus.imem_req}, 32'h1);
        check("first addr", bus.imem_addr, 32'h0);
        neg(1);                                                       // N2
        check("first inst",  inst,  32'h0050_0093);
        check("first pc4",   pc4_o, 32'h4);
        neg(3); stall_i = 1'b1;                                       // N5
        neg(1); check("hold no req n6", {31'h0, bus.imem_req}, 32'h0);
        neg(1); check("hold no req n7", {31'h0, bus.imem_req}, 32'h0);
        check("frozen pc", pc_o, 32'hC);
        neg(1); check("hold no req n8", {31'h0, bus.imem_req}, 32'h0);
        stall_i = 1'b0;                                               // N8
        neg(1); check("resume addr", bus.imem_addr, 32'h14);          // N9

        // Redirect with a slow request outstanding.
        neg(2); lat = 2; redirect_i = 1'b1; redirect_pc_i = 32'h100;  // N11
        neg(1); redirect_i = 1'b0;                                    // N12
        check("drain addr held", bus.imem_addr, 32'h1C);
        check("drain valid n12", {31'h0, valid_o}, 32'h0);
        neg(1); check("drain valid n13", {31'h0, valid_o}, 32'h0);    // N13
        neg(1);                                                       // N14
        check("redirect addr", bus.imem_addr, 32'h100);
        check("redirect req",  {31'h0, bus.imem_req}, 32'h1);
        check("redirect valid", {31'h0, valid_o}, 32'h0);
        push_ok(32'h100); push_ok(32'h104); push_ok(32'h108);
        neg(2); lat = 0;                                              // N16

        // Misaligned target, then HALT until a new redirect.
        neg(3); redirect_i = 1'b1; redirect_pc_i = 32'h102;           // N19
        push_exc(32'h102, 4'h1);
        neg(1); redirect_i = 1'b0;                                    // N20
        check("misalign no req", {31'h0, bus.imem_req}, 32'h0);
        neg(1);                                                       // N21
        check("misalign exc", {28'h0, exc_o}, 32'h1);
        check("misalign pc",  pc_o, 32'h102);
        neg(1); check("halt valid", {31'h0, valid_o}, 32'h0);         // N22
        check("halt no req n22", {31'h0, bus.imem_req}, 32'h0);
        neg(1); check("halt no req n23", {31'h0, bus.imem_req}, 32'h0);
        neg(1); redirect_i = 1'b1; redirect_pc_i = 32'h200;           // N24
        push_ok(32'h200); push_ok(32'h204);
        neg(1); redirect_i = 1'b0;                                    // N25
        check("restart addr", bus.imem_addr, 32'h200);

        // Access fault at 0x40.
        neg(2); redirect_i = 1'b1; redirect_pc_i = 32'h38;            // N27
        push_ok(32'h38); push_ok(32'h3C); push_exc(32'h40, 4'h2);
        neg(1); redirect_i = 1'b0;                                    // N28
        neg(3);                                                       // N31
        check("fault exc", {28'h0, exc_o}, 32'h2);
        check("fault pc",  pc_o, 32'h40);
        check("fault no req n31", {31'h0, bus.imem_req}, 32'h0);
        neg(1); check("fault no req n32", {31'h0, bus.imem_req}, 32'h0);

        // Redirect and ack on the same edge while stalled.
        neg(1); redirect_i = 1'b1; redirect_pc_i = 32'h80;            // N33
        push_ok(32'h80);
        neg(1); redirect_i = 1'b0;                                    // N34
        neg(1); stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300; // N35
        push_ok(32'h300);
        neg(1); stall_i = 1'b0; redirect_i = 1'b0;                    // N36
        check("rs bubble", {31'h0, valid_o}, 32'h0);
        check("rs addr", bus.imem_addr, 32'h300);

        // Fetch pc wrap, then an access fault through the skid buffer.
        neg(1); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;     // N37
        push_ok(32'hFFFF_FFF8); push_ok(32'hFFFF_FFFC); push_ok(32'h0);
        neg(1); redirect_i = 1'b0;                                    // N38
        neg(2); check("wrap pc4", pc4_o, 32'h0);                      // N40
        neg(1); stall_i = 1'b1; err_addr = 32'h4;                     // N41
        push_exc(32'h4, 4'h2);
        neg(1); check("skid fault no req", {31'h0, bus.imem_req}, 32'h0); // N42
        neg(1); stall_i = 1'b0;                                       // N43
        check("skid held pc", pc_o, 32'h0);
        neg(1);                                                       // N44
        check("skid fault exc", {28'h0, exc_o}, 32'h2);
        check("skid fault pc",  pc_o, 32'h4);
        neg(1); check("skid halt no req", {31'h0, bus.imem_req}, 32'h0);

        // Asynchronous reset mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", {31'h0, valid_o}, 32'h0);
        check("async rst pc",    pc_o, 32'h0);
        check("async rst inst",  inst, NOP);
        check("async rst req",   {31'h0, bus.imem_req}, 32'h0);
        neg(2);
        check("scoreboard drained", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
